// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-client memory arbiter: client identifiers
// and the default read-outstanding depth.
package mem_arb_pkg;

  // Client identifiers. These are also the values stored in the ID FIFO.
  localparam logic CLIENT_IMEM = 1'b0;
  localparam logic CLIENT_DMEM = 1'b1;

  // Default number of reads allowed in flight (ID FIFO depth, power of 2).
  localparam int OUTSTANDING_DEFAULT = 4;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_arb_id_fifo.sv
// 1-bit-wide synchronous FIFO that records, in issue order, which client
// each outstanding memory read belongs to. A push is ignored while full and
// a pop is ignored while empty; the arbiter never relies on either.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = OUTSTANDING_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic          mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage, wrapping pointers and occupancy count; cleared by async reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 1'b0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule : mem_arb_id_fifo

// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter between the instruction cache (client 0),
// the data cache (client 1) and a single word-granular memory port. One
// request is forwarded per cycle; read responses are steered back to their
// issuer in order using a FIFO of client IDs.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int OUTSTANDING = OUTSTANDING_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_c0_addr,
  input  logic        i_c0_ren,
  input  logic        i_c0_wen,
  input  logic [31:0] i_c0_wdata,
  output logic        o_c0_ready,
  output logic [31:0] o_c0_rdata,
  output logic        o_c0_valid,
  input  logic [31:0] i_c1_addr,
  input  logic        i_c1_ren,
  input  logic        i_c1_wen,
  input  logic [31:0] i_c1_wdata,
  output logic        o_c1_ready,
  output logic [31:0] o_c1_rdata,
  output logic        o_c1_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic        o_err
);

  logic        last_grant_r;
  logic        err_r;

  logic        req0_s;
  logic        req1_s;
  logic        any_req_s;
  logic        grant_s;
  logic        g_ren_s;
  logic        g_wen_s;
  logic        block_s;
  logic        mem_ren_s;
  logic        mem_wen_s;
  logic [31:0] mem_addr_s;
  logic [31:0] mem_wdata_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;
  logic        fifo_head_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        err_set_s;

  assign req0_s    = i_c0_ren | i_c0_wen;
  assign req1_s    = i_c1_ren | i_c1_wen;
  assign any_req_s = req0_s | req1_s;

  // Grant selection: a lone requester wins; on a tie the client that did not
  // win last time wins.
  always_comb begin
    grant_s = CLIENT_IMEM;
    if (req0_s && req1_s) begin
      grant_s = ~last_grant_r;
    end else if (req1_s) begin
      grant_s = CLIENT_DMEM;
    end else begin
      grant_s = CLIENT_IMEM;
    end
  end

  // Request mux from the granted client; a read blocks when the ID FIFO is
  // full, and a simultaneous write on the same client is dropped.
  always_comb begin
    g_ren_s     = 1'b0;
    g_wen_s     = 1'b0;
    mem_addr_s  = 32'h0000_0000;
    mem_wdata_s = 32'h0000_0000;
    if (!any_req_s) begin
      g_ren_s     = 1'b0;
      g_wen_s     = 1'b0;
      mem_addr_s  = 32'h0000_0000;
      mem_wdata_s = 32'h0000_0000;
    end else if (grant_s == CLIENT_DMEM) begin
      g_ren_s     = i_c1_ren;
      g_wen_s     = i_c1_wen;
      mem_addr_s  = i_c1_addr;
      mem_wdata_s = i_c1_wdata;
    end else begin
      g_ren_s     = i_c0_ren;
      g_wen_s     = i_c0_wen;
      mem_addr_s  = i_c0_addr;
      mem_wdata_s = i_c0_wdata;
    end
  end

  assign block_s   = g_ren_s & fifo_full_s;
  assign mem_ren_s = g_ren_s & ~block_s & ~i_rst;
  assign mem_wen_s = g_wen_s & ~g_ren_s & ~i_rst;
  assign accept_s  = (mem_ren_s | mem_wen_s) & i_mem_ready;
  assign push_s    = accept_s & mem_ren_s;
  assign pop_s     = i_mem_valid & ~fifo_empty_s & ~i_rst;

  assign o_mem_ren   = mem_ren_s;
  assign o_mem_wen   = mem_wen_s;
  assign o_mem_addr  = mem_addr_s;
  assign o_mem_wdata = mem_wdata_s;

  assign o_c0_ready = accept_s & (grant_s == CLIENT_IMEM);
  assign o_c1_ready = accept_s & (grant_s == CLIENT_DMEM);

  assign o_c0_rdata = i_mem_rdata;
  assign o_c1_rdata = i_mem_rdata;
  assign o_c0_valid = pop_s & (fifo_head_s == CLIENT_IMEM);
  assign o_c1_valid = pop_s & (fifo_head_s == CLIENT_DMEM);

  // Protocol errors: a response with nothing outstanding, or a client
  // raising read and write together.
  assign err_set_s = (i_mem_valid & fifo_empty_s) | (accept_s & g_ren_s & g_wen_s);
  assign o_err     = err_r;

  // Round-robin history and sticky error flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_grant_r <= CLIENT_IMEM;
      err_r        <= 1'b0;
    end else begin
      if (accept_s) begin
        last_grant_r <= grant_s;
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end
    end
  end

  mem_arb_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (grant_s),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (OUTSTANDING = 4).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 1 unit later, registered state after the following edge.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] c0_addr, c1_addr, c0_wdata, c1_wdata;
  logic        c0_ren, c0_wen, c1_ren, c1_wen;
  logic        c0_ready, c1_ready, c0_valid, c1_valid;
  logic [31:0] c0_rdata, c1_rdata;
  logic        mem_ready, mem_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ren, mem_wen;
  logic        err;

  int passed;
  int total;

  mem_arbiter #(.OUTSTANDING(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_c0_addr   (c0_addr),
    .i_c0_ren    (c0_ren),
    .i_c0_wen    (c0_wen),
    .i_c0_wdata  (c0_wdata),
    .o_c0_ready  (c0_ready),
    .o_c0_rdata  (c0_rdata),
    .o_c0_valid  (c0_valid),
    .i_c1_addr   (c1_addr),
    .i_c1_ren    (c1_ren),
    .i_c1_wen    (c1_wen),
    .i_c1_wdata  (c1_wdata),
    .o_c1_ready  (c1_ready),
    .o_c1_rdata  (c1_rdata),
    .o_c1_valid  (c1_valid),
    .i_mem_ready (mem_ready),
    .o_mem_addr  (mem_addr),
    .o_mem_ren   (mem_ren),
    .o_mem_wen   (mem_wen),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_valid (mem_valid),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c0_addr = 32'h0; c1_addr = 32'h0; c0_wdata = 32'h0; c1_wdata = 32'h0;
    c0_ren = 1'b0; c0_wen = 1'b0; c1_ren = 1'b0; c1_wen = 1'b0;
    mem_ready = 1'b1; mem_valid = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    c0_ren = 1'b1; c1_wen = 1'b1; mem_valid = 1'b1;
    #1;
    total++; if (c0_ready !== 1'b0) $display("FAIL rst_c0_ready got %b exp 0", c0_ready); else passed++;
    total++; if (c1_ready !== 1'b0) $display("FAIL rst_c1_ready got %b exp 0", c1_ready); else passed++;
    total++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0) $display("FAIL rst_mem_rw got %b%b exp 00", mem_ren, mem_wen); else passed++;
    total++; if (c0_valid !== 1'b0 || c1_valid !== 1'b0) $display("FAIL rst_valid got %b%b exp 00", c0_valid, c1_valid); else passed++;
    tick();
    total++; if (err !== 1'b0) $display("FAIL rst_err got %b exp 0", err); else passed++;
    idle(); rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    c0_addr = 32'h0000_0100; c0_ren = 1'b1;
    #1;
    total++; if (c0_ready !== 1'b1 || c1_ready !== 1'b0) $display("FAIL single_ready got %b%b exp 10", c0_ready, c1_ready); else passed++;
    total++; if (mem_ren !== 1'b1 || mem_addr !== 32'h0000_0100) $display("FAIL single_mem got ren=%b addr=%h exp ren=1 addr=00000100", mem_ren, mem_addr); else passed++;
    tick(); idle();
    #1;
    total++; if (mem_ren !== 1'b0 || mem_addr !== 32'h0) $display("FAIL single_idle got ren=%b addr=%h exp ren=0 addr=0", mem_ren, mem_addr); else passed++;
    tick();
    mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if (c0_valid !== 1'b1 || c1_valid !== 1'b0) $display("FAIL single_valid got %b%b exp 10", c0_valid, c1_valid); else passed++;
    total++; if (c0_rdata !== 32'hDEAD_BEEF) $display("FAIL single_rdata got %h exp deadbeef", c0_rdata); else passed++;
    tick(); idle();
    #1;
    total++; if (err !== 1'b0) $display("FAIL single_err got %b exp 0", err); else passed++;
    tick();
  endtask

  task automatic test_contention();
    logic [3:0]  exp_g;
    logic [31:0] exp_a;
    exp_g = 4'b0101;
    do_reset();
    c0_ren = 1'b1; c0_addr = 32'h0000_0200;
    c1_ren = 1'b1; c1_addr = 32'h0000_0300;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_a = exp_g[i] ? 32'h0000_0300 : 32'h0000_0200;
      total++; if (c1_ready !== exp_g[i] || c0_ready !== ~exp_g[i]) $display("FAIL contend_grant%0d got c0=%b c1=%b exp c1=%b", i, c0_ready, c1_ready, exp_g[i]); else passed++;
      total++; if (mem_addr !== exp_a) $display("FAIL contend_addr%0d got %h exp %h", i, mem_addr, exp_a); else passed++;
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_rdata = 32'h1000 + i;
      #1;
      total++; if (c1_valid !== exp_g[i] || c0_valid !== ~exp_g[i]) $display("FAIL contend_resp%0d got c0=%b c1=%b exp c1=%b", i, c0_valid, c1_valid, exp_g[i]); else passed++;
      tick();
    end
    idle();
    #1;
    total++; if (err !== 1'b0) $display("FAIL contend_err got %b exp 0", err); else passed++;
  endtask

  task automatic test_fifo_full();
    do_reset();
    c1_ren = 1'b1; c1_addr = 32'h0000_0400;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (c1_ready !== 1'b1) $display("FAIL full_accept%0d got %b exp 1", i, c1_ready); else passed++;
      tick();
    end
    #1;
    total++; if (mem_ren !== 1'b0 || c1_ready !== 1'b0) $display("FAIL full_block got ren=%b rdy=%b exp 00", mem_ren, c1_ready); else passed++;
    tick();
    mem_valid = 1'b1; mem_rdata = 32'hAAAA_0000;
    #1;
    total++; if (c1_valid !== 1'b1) $display("FAIL full_pop_valid got %b exp 1", c1_valid); else passed++;
    total++; if (mem_ren !== 1'b0 || c1_ready !== 1'b0) $display("FAIL full_pop_still_block got ren=%b rdy=%b exp 00", mem_ren, c1_ready); else passed++;
    tick();
    mem_valid = 1'b0;
    #1;
    total++; if (mem_ren !== 1'b1 || c1_ready !== 1'b1) $display("FAIL full_unblock got ren=%b rdy=%b exp 11", mem_ren, c1_ready); else passed++;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1;
      #1;
      total++; if (c1_valid !== 1'b1 || c0_valid !== 1'b0) $display("FAIL full_drain%0d got c0=%b c1=%b exp 01", i, c0_valid, c1_valid); else passed++;
      tick();
    end
    idle();
    #1;
    total++; if (err !== 1'b0) $display("FAIL full_err got %b exp 0", err); else passed++;
  endtask

  task automatic test_mixed_order();
    do_reset();
    c0_ren = 1'b1; c0_addr = 32'h0000_1000;
    #1;
    total++; if (c0_ready !== 1'b1) $display("FAIL mixed_rdA_ready got %b exp 1", c0_ready); else passed++;
    tick(); idle();
    c1_wen = 1'b1; c1_addr = 32'h0000_2000; c1_wdata = 32'h55AA_55AA;
    #1;
    total++; if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || c1_ready !== 1'b1) $display("FAIL mixed_wrB got wen=%b ren=%b rdy=%b exp 101", mem_wen, mem_ren, c1_ready); else passed++;
    total++; if (mem_wdata !== 32'h55AA_55AA || mem_addr !== 32'h0000_2000) $display("FAIL mixed_wrB_data got %h@%h exp 55aa55aa@00002000", mem_wdata, mem_addr); else passed++;
    tick(); idle();
    c1_ren = 1'b1; c1_addr = 32'h0000_3000;
    #1;
    total++; if (c1_ready !== 1'b1 || mem_addr !== 32'h0000_3000) $display("FAIL mixed_rdC got rdy=%b addr=%h exp 1 00003000", c1_ready, mem_addr); else passed++;
    tick(); idle();
    mem_valid = 1'b1; mem_rdata = 32'h1111_1111;
    #1;
    total++; if (c0_valid !== 1'b1 || c1_valid !== 1'b0 || c0_rdata !== 32'h1111_1111) $display("FAIL mixed_respX got c0=%b c1=%b d=%h exp 10 11111111", c0_valid, c1_valid, c0_rdata); else passed++;
    tick();
    mem_rdata = 32'h2222_2222;
    #1;
    total++; if (c1_valid !== 1'b1 || c0_valid !== 1'b0 || c1_rdata !== 32'h2222_2222) $display("FAIL mixed_respY got c0=%b c1=%b d=%h exp 01 22222222", c0_valid, c1_valid, c1_rdata); else passed++;
    tick(); idle();
    #1;
    total++; if (err !== 1'b0) $display("FAIL mixed_err got %b exp 0", err); else passed++;
  endtask

  task automatic test_backpressure_err();
    do_reset();
    c0_ren = 1'b1; c0_addr = 32'h0000_0500; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (c0_ready !== 1'b0 || mem_ren !== 1'b1 || mem_addr !== 32'h0000_0500) $display("FAIL bp_hold%0d got rdy=%b ren=%b addr=%h exp 0 1 00000500", i, c0_ready, mem_ren, mem_addr); else passed++;
      tick();
    end
    mem_ready = 1'b1;
    #1;
    total++; if (c0_ready !== 1'b1) $display("FAIL bp_accept got %b exp 1", c0_ready); else passed++;
    tick(); idle();
    mem_valid = 1'b1;
    #1;
    total++; if (c0_valid !== 1'b1) $display("FAIL bp_resp got %b exp 1", c0_valid); else passed++;
    tick(); idle();
    #1;
    total++; if (err !== 1'b0) $display("FAIL bp_err_clean got %b exp 0", err); else passed++;
    mem_valid = 1'b1;
    #1;
    total++; if (c0_valid !== 1'b0 || c1_valid !== 1'b0) $display("FAIL spur_valid got %b%b exp 00", c0_valid, c1_valid); else passed++;
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (err !== 1'b1) $display("FAIL spur_err_sticky%0d got %b exp 1", i, err); else passed++;
      tick();
    end
    do_reset();
    total++; if (err !== 1'b0) $display("FAIL spur_err_cleared got %b exp 0", err); else passed++;
  endtask

  task automatic test_rw_conflict();
    do_reset();
    c0_ren = 1'b1; c0_wen = 1'b1; c0_addr = 32'h0000_0600;
    #1;
    total++; if (mem_ren !== 1'b1 || mem_wen !== 1'b0 || c0_ready !== 1'b1) $display("FAIL rw_issue got ren=%b wen=%b rdy=%b exp 101", mem_ren, mem_wen, c0_ready); else passed++;
    tick(); idle();
    #1;
    total++; if (err !== 1'b1) $display("FAIL rw_err got %b exp 1", err); else passed++;
    do_reset();
  endtask

  task automatic test_async_reset();
    do_reset();
    c0_ren = 1'b1; c0_addr = 32'h0000_0700;
    tick(); idle();
    c1_ren = 1'b1; c1_addr = 32'h0000_0800;
    tick(); idle();
    c0_ren = 1'b1; c0_addr = 32'h0000_0900;
    #1;
    total++; if (mem_ren !== 1'b1) $display("FAIL ar_pre_ren got %b exp 1", mem_ren); else passed++;
    rst = 1'b1; mem_valid = 1'b1;
    #1;
    total++; if (mem_ren !== 1'b0 || c0_ready !== 1'b0) $display("FAIL ar_immediate got ren=%b rdy=%b exp 00", mem_ren, c0_ready); else passed++;
    total++; if (c0_valid !== 1'b0 || c1_valid !== 1'b0) $display("FAIL ar_valid got %b%b exp 00", c0_valid, c1_valid); else passed++;
    tick(); idle();
    rst = 1'b0;
    tick();
    mem_valid = 1'b1;
    #1;
    total++; if (c0_valid !== 1'b0 || c1_valid !== 1'b0) $display("FAIL ar_stale_valid got %b%b exp 00", c0_valid, c1_valid); else passed++;
    tick(); idle();
    #1;
    total++; if (err !== 1'b1) $display("FAIL ar_stale_err got %b exp 1", err); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    idle();
    #1;
    test_reset();
    test_single_read();
    test_contention();
    test_fifo_full();
    test_mixed_order();
    test_backpressure_err();
    test_rw_conflict();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_mem_arbiter
